vs_fp_div_seq: RTL and testbench

//  Sequential signed fixed-point divider: result = a / b, with a, b and result in N-bit
//    2's-complement Q-format (Q fractional bits).

---
 rtl/vs_fp_div_seq_if.sv | 26 ++
 rtl/vs_fp_div_seq.sv | 142 ++++++++++++++
 tb/tb_vs_fp_div_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vs_fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
// The master drives operands and out_ready; the slave (divider) drives results, flags and status.
interface vs_fp_div_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         overflow;
    logic         div_by_zero;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, div_by_zero, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, div_by_zero, busy
    );
endinterface

// File: rtl/vs_fp_div_seq.sv
// Signed Q-format restoring divider, one quotient bit per clock; out_valid N+Q+2 edges after accept.
// Result and flags are held in DONE until out_ready; operands are accepted only in IDLE.
module vs_fp_div_seq #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input logic            clock,
    input logic            reset_n,
    vs_fp_div_seq_if.slave bus
);
    localparam int ITER = N + Q;
    localparam int CW   = $clog2(ITER);
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} state_t;

    state_t          state_q;
    logic            sign_q;
    logic            a_neg_q;
    logic            dbz_q;
    logic [N-1:0]    mag_b_q;
    logic [N-1:0]    rem_q;
    logic [ITER-1:0] dvd_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    result_q;
    logic            overflow_q;
    logic            div_by_zero_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            busy_q;

    logic [N-1:0]    mag_a;
    logic [N-1:0]    mag_b;
    logic [N:0]      rem_sh;
    logic [N:0]      diff;
    logic            q_bit;
    logic [N-1:0]    rem_d;
    logic            too_big;
    logic [N-1:0]    q_abs;
    logic [N-1:0]    fix_result_d;
    logic            unused_diff_msb;

    // Magnitudes as N-bit unsigned: -2^(N-1) maps exactly onto 2^(N-1).
    always_comb begin
        mag_a = bus.a[N-1] ? -bus.a : bus.a;
        mag_b = bus.b[N-1] ? -bus.b : bus.b;
    end

    always_comb begin
        rem_sh          = {rem_q, dvd_q[ITER-1]};
        diff            = rem_sh - {1'b0, mag_b_q};
        q_bit           = (rem_sh >= {1'b0, mag_b_q});
        rem_d           = q_bit ? diff[N-1:0] : rem_sh[N-1:0];
        unused_diff_msb = diff[N];
    end

    // After DIVIDE the shift register holds the full ITER-bit quotient magnitude.
    always_comb begin
        too_big = |dvd_q[ITER-1:N-1];
        q_abs   = {1'b0, dvd_q[N-2:0]};
        if (dbz_q) begin
            fix_result_d = a_neg_q ? SAT_NEG : SAT_POS;
        end else if (too_big) begin
            fix_result_d = sign_q ? SAT_NEG : SAT_POS;
        end else begin
            fix_result_d = sign_q ? -q_abs : q_abs;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            a_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            mag_b_q       <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sign_q        <= bus.a[N-1] ^ bus.b[N-1];
                        a_neg_q       <= bus.a[N-1];
                        dbz_q         <= (bus.b == '0);
                        mag_b_q       <= mag_b;
                        dvd_q         <= {mag_a, {Q{1'b0}}};
                        rem_q         <= '0;
                        cnt_q         <= CW'(ITER - 1);
                        overflow_q    <= 1'b0;
                        div_by_zero_q <= 1'b0;
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[ITER-2:0], q_bit};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    result_q      <= fix_result_d;
                    div_by_zero_q <= dbz_q;
                    overflow_q    <= !dbz_q && too_big;
                    state_q       <= DONE;
                end
                DONE: begin
                    // out_valid trails the result register by one edge.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vs_fp_div_seq.sv
// Directed bench for vs_fp_div_seq: vector table plus backpressure and mid-divide reset sequences.
module tb_vs_fp_div_seq;
    localparam int N   = 32;
    localparam int Q   = 15;
    localparam int LAT = N + Q + 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    vs_fp_div_seq_if #(.N(N)) bus ();

    vs_fp_div_seq #(.N(N), .Q(Q)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         ovf;
        logic         dbz;
        string        name;
    } vec_t;

    vec_t vecs [14];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!bus.out_valid && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk({name, "/latency"}, k, LAT);
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clock);
        chk({v.name, "/in_ready_idle"}, bus.in_ready, 1);
        bus.a        = v.a;
        bus.b        = v.b;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        chk({v.name, "/busy"}, bus.busy, 1);
        chk({v.name, "/in_ready_busy"}, bus.in_ready, 0);
        wait_valid(v.name);
        chk({v.name, "/result"}, bus.result, v.res);
        chk({v.name, "/overflow"}, bus.overflow, v.ovf);
        chk({v.name, "/div_by_zero"}, bus.div_by_zero, v.dbz);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        chk({v.name, "/out_valid_drop"}, bus.out_valid, 0);
        chk({v.name, "/in_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{32'h0003_0000, 32'h0001_0000, 32'h0001_8000, 1'b0, 1'b0, "six_by_two"};
        vecs[1]  = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, "third"};
        vecs[2]  = '{32'hFFFF_8000, 32'h0001_8000, 32'hFFFF_D556, 1'b0, 1'b0, "neg_third"};
        vecs[3]  = '{32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, "dbz_pos"};
        vecs[4]  = '{32'hFFFF_8000, 32'h0000_0000, 32'h8000_0001, 1'b0, 1'b1, "dbz_neg"};
        vecs[5]  = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, "ovf_pos"};
        vecs[6]  = '{32'h8000_0000, 32'h0000_8000, 32'h8000_0001, 1'b1, 1'b0, "ovf_neg"};
        vecs[7]  = '{32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_8000, 1'b0, 1'b0, "pos_by_neg"};
        vecs[8]  = '{32'hFFFE_8000, 32'hFFFF_4000, 32'h0001_0000, 1'b0, 1'b0, "neg_by_neg"};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b0, "max_exact"};
        vecs[10] = '{32'h8000_0001, 32'h0000_8000, 32'h8000_0001, 1'b0, 1'b0, "min_exact"};
        vecs[11] = '{32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, "trunc_to_zero"};
        vecs[12] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, "zero_by_zero"};
        vecs[13] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_8000, 1'b0, 1'b0, "min_by_min"};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset/in_ready", bus.in_ready, 1);
        chk("reset/out_valid", bus.out_valid, 0);
        chk("reset/busy", bus.busy, 0);
        chk("reset/result", bus.result, 0);
        chk("reset/overflow", bus.overflow, 0);
        chk("reset/div_by_zero", bus.div_by_zero, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i]);
        end

        // Backpressure: hold out_ready low for 10 cycles while poking in_valid.
        @(negedge clock);
        bus.a        = 32'h0003_0000;
        bus.b        = 32'h0001_0000;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = '0;
            @(posedge clock);
            #1;
            bus.in_valid = 1'b0;
            chk("bp/result_hold", bus.result, 32'h0001_8000);
            chk("bp/overflow_hold", bus.overflow, 0);
            chk("bp/dbz_hold", bus.div_by_zero, 0);
            chk("bp/in_ready_low", bus.in_ready, 0);
            chk("bp/out_valid_hold", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        chk("bp/out_valid_release", bus.out_valid, 0);
        chk("bp/in_ready_release", bus.in_ready, 1);
        chk("bp/busy_release", bus.busy, 0);
        run_op(vecs[2]);

        // Reset during DIVIDE, after a saturating op left a non-zero result behind.
        run_op(vecs[5]);
        @(negedge clock);
        bus.a        = 32'h0003_0000;
        bus.b        = 32'h0001_0000;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst/in_ready", bus.in_ready, 1);
        chk("midrst/out_valid", bus.out_valid, 0);
        chk("midrst/busy", bus.busy, 0);
        chk("midrst/result", bus.result, 0);
        chk("midrst/overflow", bus.overflow, 0);
        chk("midrst/div_by_zero", bus.div_by_zero, 0);
        reset_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) seen = 1;
        end
        chk("midrst/no_output", seen, 0);
        run_op(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
